// File: rtl/ayatsuki_bus_arbiter_if.sv
// Per-master bus port of the ayatsuki SoC data bus: request/address/data in, grant and read response out.
interface ayatsuki_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/ayatsuki_bus_arbiter.sv
// Two-master round-robin arbiter with burst cap, slave decode and 1-cycle registered read return.
// Optional macro AYATSUKI_BUS_ERR_EN: flags unmapped high addresses with bus_err and 32'hDEAD_BEEF read data.
module ayatsuki_bus_arbiter #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TIM_BASE  = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] TIM_END   = 32'h8000_000F,
  parameter logic [ADDR_W-1:0] UART_BASE = 32'h8000_0010,
  parameter logic [ADDR_W-1:0] UART_END  = 32'h8000_001F,
  parameter int              MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ayatsuki_bus_arbiter_if.slave m0,
  ayatsuki_bus_arbiter_if.slave m1,
  output logic                  s_re,
  output logic                  s_we,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic                  ram_sel,
  output logic                  tim_sel,
  output logic                  uart_sel,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic [DATA_W-1:0]     tim_rdata,
  input  logic [DATA_W-1:0]     uart_rdata,
`ifdef AYATSUKI_BUS_ERR_EN
  output logic                  bus_err,
`endif
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {TGT_RAM, TGT_TIM, TGT_UART, TGT_ERR} tgt_e;

  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  tgt_e             rd_tgt_q, rd_tgt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef AYATSUKI_BUS_ERR_EN
  logic             err_q, err_d;
`endif

  logic             gnt0, gnt1, any_gnt, win, pick, we_w;
  tgt_e             tgt_w;
  logic [DATA_W-1:0] rsp_data;
  logic             rvalid0, rvalid1;

  // Grant: burst_cnt_q != 0 means the last winner also held the bus in the previous cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    pick = 1'b0;
    if (!rst) begin
      case ({m1.req, m0.req})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (burst_cnt_q != BURST_MAX && burst_cnt_q != '0) pick = last_gnt_q;
          else                                              pick = ~last_gnt_q;
          gnt0 = ~pick;
          gnt1 = pick;
        end
        default: ;
      endcase
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign win     = gnt1;
  assign m0.gnt  = gnt0;
  assign m1.gnt  = gnt1;

  // Issue and decode
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    we_w    = 1'b0;
    if (gnt1) begin
      s_addr  = m1.addr;
      s_wdata = m1.wdata;
      we_w    = m1.we;
    end else if (gnt0) begin
      s_addr  = m0.addr;
      s_wdata = m0.wdata;
      we_w    = m0.we;
    end
  end

  always_comb begin
    if (s_addr >= TIM_BASE && s_addr <= TIM_END)        tgt_w = TGT_TIM;
    else if (s_addr >= UART_BASE && s_addr <= UART_END) tgt_w = TGT_UART;
`ifdef AYATSUKI_BUS_ERR_EN
    else if (s_addr[ADDR_W-1])                          tgt_w = TGT_ERR;
`endif
    else                                                tgt_w = TGT_RAM;
  end

  always_comb begin
    s_re     = any_gnt & ~we_w & (tgt_w != TGT_ERR);
    s_we     = any_gnt &  we_w & (tgt_w != TGT_ERR);
    ram_sel  = any_gnt & (tgt_w == TGT_RAM);
    tim_sel  = any_gnt & (tgt_w == TGT_TIM);
    uart_sel = any_gnt & (tgt_w == TGT_UART);
  end

  // Next state for arbitration and the pending read
  always_comb begin
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = '0;
    if (any_gnt) begin
      if (win == last_gnt_q && burst_cnt_q != '0)
        burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + CNT_W'(1);
      else
        burst_cnt_d = CNT_W'(1);
      last_gnt_d = win;
    end
    rd_pend_d  = any_gnt & ~we_w;
    rd_owner_d = rd_pend_d ? win : rd_owner_q;
    rd_tgt_d   = rd_pend_d ? tgt_w : rd_tgt_q;
`ifdef AYATSUKI_BUS_ERR_EN
    err_d      = any_gnt & (tgt_w == TGT_ERR);
`endif
  end

  // Read return stage
  always_comb begin
    case (rd_tgt_q)
      TGT_RAM:  rsp_data = ram_rdata;
      TGT_TIM:  rsp_data = tim_rdata;
      TGT_UART: rsp_data = uart_rdata;
      default:  rsp_data = DATA_W'(32'hDEAD_BEEF);
    endcase
    rvalid0  = ~rst & rd_pend_q & ~rd_owner_q;
    rvalid1  = ~rst & rd_pend_q &  rd_owner_q;
    rdata0_d = rvalid0 ? rsp_data : rdata0_q;
    rdata1_d = rvalid1 ? rsp_data : rdata1_q;
  end

  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0_d;
  assign m1.rdata  = rdata1_d;
  assign busy      = ~rst & rd_pend_q;
`ifdef AYATSUKI_BUS_ERR_EN
  assign bus_err   = ~rst & err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_tgt_q    <= TGT_RAM;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef AYATSUKI_BUS_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      rd_tgt_q    <= rd_tgt_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef AYATSUKI_BUS_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ayatsuki_bus_arbiter.sv
// Scoreboard bench for ayatsuki_bus_arbiter: a reference arbiter model predicts grants and pushes read responses.
module tb_ayatsuki_bus_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_re, s_we, ram_sel, tim_sel, uart_sel, busy;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] ram_rdata = 32'h0, tim_rdata = 32'h0, uart_rdata = 32'h0;
`ifdef AYATSUKI_BUS_ERR_EN
  logic        bus_err;
`endif

  ayatsuki_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  ayatsuki_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  ayatsuki_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .s_re       (s_re),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .ram_sel    (ram_sel),
    .tim_sel    (tim_sel),
    .uart_sel   (uart_sel),
    .ram_rdata  (ram_rdata),
    .tim_rdata  (tim_rdata),
    .uart_rdata (uart_rdata),
`ifdef AYATSUKI_BUS_ERR_EN
    .bus_err    (bus_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit owner; int tgt;} rsp_t;
  rsp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          ml_last = 1;
  int          ml_burst = 0;
  logic [31:0] hold0 = 32'h0, hold1 = 32'h0;
  bit          err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 0 RAM, 1 timer, 2 UART, 3 unmapped
  function automatic int tb_decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h8000_000F) return 1;
    if (a >= 32'h8000_0010 && a <= 32'h8000_001F) return 2;
`ifdef AYATSUKI_BUS_ERR_EN
    if (a[31]) return 3;
`endif
    return 0;
  endfunction

  task automatic cyc(input bit r,
                     input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    int          win;
    int          tgt;
    bit          we;
    logic [31:0] addr, wd, rsp;
    bit          rv0, rv1;
    rsp_t        e;
    rst = r;
    m0_if.req = q0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = q1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    @(negedge clk);
    win = -1;
    if (!r) begin
      if (q0 && !q1)      win = 0;
      else if (q1 && !q0) win = 1;
      else if (q0 && q1) begin
        if (ml_burst == MAXB)  win = 1 - ml_last;
        else if (ml_burst > 0) win = ml_last;
        else                   win = 1 - ml_last;
      end
    end
    check_eq("m0_gnt", m0_if.gnt, 32'(win == 0));
    check_eq("m1_gnt", m1_if.gnt, 32'(win == 1));
    we = 1'b0; tgt = 0;
    if (win >= 0) begin
      we   = (win == 1) ? w1 : w0;
      addr = (win == 1) ? a1 : a0;
      wd   = (win == 1) ? d1 : d0;
      tgt  = tb_decode(addr);
      check_eq("s_re", s_re, 32'(!we && tgt != 3));
      check_eq("s_we", s_we, 32'(we && tgt != 3));
      check_eq("s_addr", s_addr, addr);
      if (we) check_eq("s_wdata", s_wdata, wd);
      check_eq("ram_sel", ram_sel, 32'(tgt == 0));
      check_eq("tim_sel", tim_sel, 32'(tgt == 1));
      check_eq("uart_sel", uart_sel, 32'(tgt == 2));
    end else begin
      check_eq("idle_strobe", {30'b0, s_re, s_we}, 32'h0);
      check_eq("idle_sel", {29'b0, ram_sel, tim_sel, uart_sel}, 32'h0);
    end
    rv0 = 1'b0; rv1 = 1'b0;
    if (!r && sb.size() > 0) begin
      e = sb.pop_front();
      case (e.tgt)
        0:       rsp = ram_rdata;
        1:       rsp = tim_rdata;
        2:       rsp = uart_rdata;
        default: rsp = 32'hDEAD_BEEF;
      endcase
      if (e.owner) begin rv1 = 1'b1; hold1 = rsp; end
      else         begin rv0 = 1'b1; hold0 = rsp; end
    end
    check_eq("m0_rvalid", m0_if.rvalid, 32'(rv0));
    check_eq("m1_rvalid", m1_if.rvalid, 32'(rv1));
    check_eq("m0_rdata", m0_if.rdata, hold0);
    check_eq("m1_rdata", m1_if.rdata, hold1);
    check_eq("busy", busy, 32'(rv0 | rv1));
`ifdef AYATSUKI_BUS_ERR_EN
    check_eq("bus_err", bus_err, 32'(!r && err_exp));
`endif
    if (r) begin
      ml_last = 1; ml_burst = 0; sb.delete();
      hold0 = 32'h0; hold1 = 32'h0; err_exp = 1'b0;
    end else begin
      err_exp = 1'b0;
      if (win >= 0) begin
        if (win == ml_last && ml_burst > 0) ml_burst = (ml_burst == MAXB) ? MAXB : ml_burst + 1;
        else                                ml_burst = 1;
        ml_last = win;
        if (!we) begin e.owner = (win == 1); e.tgt = tgt; sb.push_back(e); end
        if (tgt == 3) err_exp = 1'b1;
      end else begin
        ml_burst = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return $urandom & 32'h0000_FFFC;
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 15));
      2:       return 32'h8000_0010 + 32'($urandom_range(0, 15));
      3:       return 32'h9000_0000;
      default: return 32'h8000_0020;
    endcase
  endfunction

  initial begin
    tim_rdata  = 32'h7117_0001;
    uart_rdata = 32'h0A27_0002;
    ram_rdata  = 32'h1234_5678;
    // reset with both masters requesting
    cyc(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    cyc(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    // m0 alone reads RAM, response next cycle
    cyc(0, 1, 0, 32'h0000_0040, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // continuous contention: 4/4 round robin
    for (int i = 0; i < 12; i++) begin
      ram_rdata = 32'hA000_0000 + 32'(i);
      cyc(0, 1, 0, 32'h100 + 32'(4*i), 0, 1, 0, 32'h200 + 32'(4*i), 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // alternating single requests
    cyc(0, 1, 0, 32'h44, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h48, 0);
    cyc(0, 1, 1, 32'h4C, 32'h55, 0, 0, 0, 0);
    // decode: UART write, timer read, UART read
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0014, 32'h41);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h8000_0004, 0);
    cyc(0, 1, 0, 32'h8000_001C, 0, 0, 0, 0, 0);
    // write issued in the same cycle as a read response
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 32'hCAFE);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back reads with changing RAM data
    for (int i = 0; i < 4; i++) begin
      ram_rdata = 32'hB0B0_0000 + 32'(i);
      cyc(0, 1, 0, 32'h300 + 32'(4*i), 0, 0, 0, 0, 0);
    end
    // read in flight dropped by reset
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h400, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // unmapped high address
    cyc(0, 1, 0, 32'h9000_0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      ram_rdata  = $urandom;
      tim_rdata  = $urandom;
      uart_rdata = $urandom;
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
